// File: rtl/simple_pkg.sv
// Shared widths, fetch-state encoding and the default halt opcode for the fetch stage.
package simple_pkg;
    localparam int WORD_W     = 16;
    localparam int NUM_PHASES = 5;

    localparam logic [WORD_W-1:0] DEF_HALT_WORD = 16'hC0F0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_phase_check.sv
// Decodes the phase strobes into the two phases the fetch stage acts on, and flags
// any cycle where the phase controller drives more than one strobe.
module fetch_phase_check
    import simple_pkg::*;
(
    input  logic [NUM_PHASES-1:0] phase,
    output logic                  is_p0,
    output logic                  is_p4,
    output logic                  multi_hot
);
    logic [NUM_PHASES-1:0] phase_m1;

    assign phase_m1  = phase - 1'b1;
    assign is_p0     = phase[0];
    assign is_p4     = phase[NUM_PHASES-1];
    // clearing the lowest set bit leaves something only when two or more were set
    assign multi_hot = |(phase & phase_m1);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests on phase 0, captures the word while in FETCH,
// and advances or redirects the pc on phase 4; freezes on the halt opcode.
module fetch_unit
    import simple_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  phase,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        halted,
    output logic        phase_err
);
    fetch_state_t state, state_n;
    logic [15:0]  pc_q, pc_n;
    logic [15:0]  ir_q, ir_n;
    logic         irv_q, irv_n;
    logic         err_q, err_n;
    logic         is_p0, is_p4, multi_hot;

    fetch_phase_check u_phase (
        .phase     (phase),
        .is_p0     (is_p0),
        .is_p4     (is_p4),
        .multi_hot (multi_hot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            ir_q  <= 16'h0000;
            irv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            ir_q  <= ir_n;
            irv_q <= irv_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        ir_n    = ir_q;
        irv_n   = irv_q;
        err_n   = err_q;
        imem_rd = 1'b0;
        // a malformed phase word freezes the stage for the cycle; HALTED ignores it entirely
        if (multi_hot && state != HALTED) begin
            err_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_p0) begin
                        imem_rd = 1'b1;
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        ir_n    = imem_rdata;
                        irv_n   = 1'b1;
                        state_n = HOLD;
                    end else if (is_p4) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                HOLD: begin
                    if (is_p4) begin
                        if (ir_q == HALT_WORD) begin
                            state_n = HALTED;
                        end else begin
                            pc_n    = branch_taken ? branch_target : pc_q + 16'd1;
                            irv_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
                HALTED: ;
                default: state_n = IDLE;
            endcase
        end
        if (reset) imem_rd = 1'b0;
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = irv_q;
    assign halted    = (state == HALTED);
    assign phase_err = err_q;
endmodule
